// File: rtl/iob_ddr_init_seq_pkg.sv
// Shared definitions for the DDR init sequencer.
// Contents: the state width and the state encoding. The encoding is visible
// on state_o, so the enum values are fixed.
package iob_ddr_init_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IOB_DDR_INIT_RST    = 3'd0,
        IOB_DDR_INIT_WAIT   = 3'd1,
        IOB_DDR_INIT_SETTLE = 3'd2,
        IOB_DDR_INIT_RUN    = 3'd3,
        IOB_DDR_INIT_FAIL   = 3'd4
    } state_e;

endpackage

// File: rtl/iob_sat_counter.sv
// Saturating event counter. It stops at all-ones and never wraps.
// Ports:
//   clk_i    - clock
//   arstn_i  - asynchronous active-low reset; the count clears to 0
//   en_i     - clock enable; the count holds while low
//   clear_i  - synchronous clear; it takes priority over incr_i
//   incr_i   - add one unless the count is already saturated
//   cnt_o    - current count
module iob_sat_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             arstn_i,
    input  logic             en_i,
    input  logic             clear_i,
    input  logic             incr_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            if (clear_i) begin
                cnt_d = '0;
            end else if (incr_i && (cnt_q != '1)) begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/iob_sync.sv
// Two-flop synchroniser for signals that are asynchronous to clk_i.
// Ports:
//   clk_i    - destination clock
//   arstn_i  - asynchronous active-low reset; both stages clear to 0
//   en_i     - clock enable; both stages hold while low
//   d_i      - asynchronous input
//   q_o      - synchronised output, two enabled cycles behind d_i
module iob_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             arstn_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = meta_q;
        sync_d = sync_q;
        if (en_i) begin
            meta_d = d_i;
            sync_d = meta_q;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/iob_ddr_init_seq.sv
// Power-up and recovery sequencer for the DDR memory subsystem.
// It holds the DDR controller in reset, waits for calibration (with a
// timeout and retries), and requires calibration to stay stable before it
// releases the SoC reset. If calibration is lost while in RUN, it starts the
// sequence again.
// Ports:
//   clk_i         - system clock
//   arstn_i       - asynchronous active-low reset
//   cke_i         - clock enable; all state, counters and outputs hold while low
//   calib_done_i  - DDR calibration done; asynchronous to clk_i
//   retry_i       - single-cycle pulse that restarts the sequence from FAIL
//   ddr_rst_o     - active-high reset to the DDR controller
//   soc_arst_o    - active-high reset to the SoC
//   ready_o       - high only in RUN
//   fail_o        - high only in FAIL
//   retries_o     - failed attempts since the last entry to RUN (saturating)
//   losses_o      - calibration losses seen in RUN since reset (saturating)
//   state_o       - encoded state, for debug
//
// state      | meaning
// RST_DDR    | DDR controller held in reset for RST_CYCLES cycles
// WAIT_CALIB | waiting for calibration, bounded by TIMEOUT_CYCLES
// SETTLE     | calibration must stay high for SETTLE_CYCLES cycles
// RUN        | SoC released; any loss of calibration re-sequences
// FAIL       | retries used up; waits for retry_i
module iob_ddr_init_seq
    import iob_ddr_init_seq_pkg::*;
#(
    parameter int RST_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 2**22,
    parameter int SETTLE_CYCLES  = 64,
    parameter int MAX_RETRIES    = 3,
    parameter int CNT_W          = 23,
    parameter int RETRY_W        = 4
) (
    input  logic               clk_i,
    input  logic               arstn_i,
    input  logic               cke_i,
    input  logic               calib_done_i,
    input  logic               retry_i,
    output logic               ddr_rst_o,
    output logic               soc_arst_o,
    output logic               ready_o,
    output logic               fail_o,
    output logic [RETRY_W-1:0] retries_o,
    output logic [RETRY_W-1:0] losses_o,
    output logic [STATE_W-1:0] state_o
);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ddr_rst_q, ddr_rst_d;
    logic             soc_arst_q, soc_arst_d;
    logic             ready_q, ready_d;
    logic             fail_q, fail_d;
    logic             cal;
    logic             retry_incr, retry_clr, loss_incr;

    iob_sync #(.WIDTH(1)) u_cal_sync (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .en_i    (cke_i),
        .d_i     (calib_done_i),
        .q_o     (cal)
    );

    iob_sat_counter #(.WIDTH(RETRY_W)) u_retries (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .en_i    (cke_i),
        .clear_i (retry_clr),
        .incr_i  (retry_incr),
        .cnt_o   (retries_o)
    );

    iob_sat_counter #(.WIDTH(RETRY_W)) u_losses (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .en_i    (cke_i),
        .clear_i (1'b0),
        .incr_i  (loss_incr),
        .cnt_o   (losses_o)
    );

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= IOB_DDR_INIT_RST;
            cnt_q   <= '0;
        end else if (cke_i) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter runs only in the timed states. It is cleared on entry to
    // RUN and FAIL, so it stays at zero there.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        retry_incr = 1'b0;
        retry_clr  = 1'b0;
        loss_incr  = 1'b0;
        case (state_q)
            IOB_DDR_INIT_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = IOB_DDR_INIT_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            IOB_DDR_INIT_WAIT: begin
                // If calibration arrives on the timeout cycle, calibration wins.
                if (cal) begin
                    state_d = IOB_DDR_INIT_SETTLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retry_incr = 1'b1;
                    cnt_d      = '0;
                    if (int'(retries_o) + 1 >= MAX_RETRIES) begin
                        state_d = IOB_DDR_INIT_FAIL;
                    end else begin
                        state_d = IOB_DDR_INIT_RST;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            IOB_DDR_INIT_SETTLE: begin
                if (!cal) begin
                    state_d = IOB_DDR_INIT_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d   = IOB_DDR_INIT_RUN;
                    cnt_d     = '0;
                    retry_clr = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            IOB_DDR_INIT_RUN: begin
                if (!cal) begin
                    state_d   = IOB_DDR_INIT_RST;
                    cnt_d     = '0;
                    loss_incr = 1'b1;
                end
            end
            IOB_DDR_INIT_FAIL: begin
                if (retry_i) begin
                    state_d   = IOB_DDR_INIT_RST;
                    cnt_d     = '0;
                    retry_clr = 1'b1;
                end
            end
            default: begin
                state_d = IOB_DDR_INIT_RST;
                cnt_d   = '0;
            end
        endcase
    end

    // The output flops are decoded from the next state, so each output
    // changes on the same edge as the state register.
    always_comb begin
        ddr_rst_d  = (state_d == IOB_DDR_INIT_RST);
        soc_arst_d = (state_d != IOB_DDR_INIT_RUN);
        ready_d    = (state_d == IOB_DDR_INIT_RUN);
        fail_d     = (state_d == IOB_DDR_INIT_FAIL);
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            ddr_rst_q  <= 1'b1;
            soc_arst_q <= 1'b1;
            ready_q    <= 1'b0;
            fail_q     <= 1'b0;
        end else if (cke_i) begin
            ddr_rst_q  <= ddr_rst_d;
            soc_arst_q <= soc_arst_d;
            ready_q    <= ready_d;
            fail_q     <= fail_d;
        end
    end

    assign ddr_rst_o  = ddr_rst_q;
    assign soc_arst_o = soc_arst_q;
    assign ready_o    = ready_q;
    assign fail_o     = fail_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_iob_ddr_init_seq.sv
// Bench for iob_ddr_init_seq. It pushes the expected state transitions to a
// queue, with the retry and loss counts and, where known, the number of
// cycles spent in the previous state. A negedge monitor pops and compares
// one entry at every state change.
module tb_iob_ddr_init_seq;

    localparam int ST_RST = 0, ST_WAIT = 1, ST_SETTLE = 2, ST_RUN = 3, ST_FAIL = 4;

    logic       clk = 1'b0;
    logic       arstn = 1'b0;
    logic       cke = 1'b1;
    logic       calib = 1'b0;
    logic       retry = 1'b0;
    logic       ddr_rst, soc_arst, ready, fail;
    logic [3:0] retries, losses;
    logic [2:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int st;
        int ret;
        int los;
        int dwell;
    } exp_t;

    exp_t sb_q[$];

    iob_ddr_init_seq #(
        .RST_CYCLES     (4),
        .TIMEOUT_CYCLES (20),
        .SETTLE_CYCLES  (8),
        .MAX_RETRIES    (3),
        .CNT_W          (8),
        .RETRY_W        (4)
    ) dut (
        .clk_i        (clk),
        .arstn_i      (arstn),
        .cke_i        (cke),
        .calib_done_i (calib),
        .retry_i      (retry),
        .ddr_rst_o    (ddr_rst),
        .soc_arst_o   (soc_arst),
        .ready_o      (ready),
        .fail_o       (fail),
        .retries_o    (retries),
        .losses_o     (losses),
        .state_o      (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic exp_push(input int st, input int ret, input int los, input int dwell);
        exp_t e;
        e.st = st; e.ret = ret; e.los = los; e.dwell = dwell;
        sb_q.push_back(e);
    endtask

    // Monitor: counts negedge samples per state while out of reset.
    int prev_st = ST_RST;
    int dwell   = 0;
    always @(negedge clk) begin
        if (!arstn) begin
            prev_st = ST_RST;
            dwell   = 0;
        end else if (int'(state) != prev_st) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_state", int'(state), prev_st);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("state", int'(state), e.st);
                chk("retries", int'(retries), e.ret);
                chk("losses", int'(losses), e.los);
                if (e.dwell >= 0) chk("dwell", dwell, e.dwell);
                chk("ddr_rst", int'(ddr_rst), int'(e.st == ST_RST));
                chk("soc_arst", int'(soc_arst), int'(e.st != ST_RUN));
                chk("ready", int'(ready), int'(e.st == ST_RUN));
                chk("fail", int'(fail), int'(e.st == ST_FAIL));
            end
            prev_st = int'(state);
            dwell   = 1;
        end else begin
            dwell++;
        end
    end

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (sb_q.size() == 0) break;
        end
        chk("drain_pending", sb_q.size(), 0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_state", int'(state), ST_RST);
        chk("rst_ddr_rst", int'(ddr_rst), 1);
        chk("rst_soc_arst", int'(soc_arst), 1);
        chk("rst_ready", int'(ready), 0);
        chk("rst_fail", int'(fail), 0);
        chk("rst_retries", int'(retries), 0);
        chk("rst_losses", int'(losses), 0);
    endtask

    // Asserts reset, checks the reset values, then releases reset 2 time
    // units after a rising edge. That edge is the reference P0 for the tests.
    task automatic do_reset();
        @(posedge clk); #2;
        arstn = 1'b0; calib = 1'b0; retry = 1'b0; cke = 1'b1;
        @(negedge clk);
        chk_reset_vals();
        repeat (2) @(posedge clk);
        #2 arstn = 1'b1;
    endtask

    task automatic pulse_retry();
        @(posedge clk); #2 retry = 1'b1;
        @(posedge clk); #2 retry = 1'b0;
    endtask

    initial begin
        // 1. Nominal: calibration input rises after P10 and is seen at P13.
        do_reset();
        exp_push(ST_WAIT, 0, 0, 4);
        exp_push(ST_SETTLE, 0, 0, 9);
        exp_push(ST_RUN, 0, 0, 8);
        repeat (10) @(posedge clk);
        #2 calib = 1'b1;
        wait_drain(200);

        // 2. Glitchy: a 3-cycle pulse during SETTLE, then a stable high.
        do_reset();
        exp_push(ST_WAIT, 0, 0, 4);
        exp_push(ST_SETTLE, 0, 0, 4);
        exp_push(ST_WAIT, 0, 0, 3);
        exp_push(ST_SETTLE, 0, 0, 4);
        exp_push(ST_RUN, 0, 0, 8);
        repeat (5) @(posedge clk);
        #2 calib = 1'b1;
        repeat (3) @(posedge clk);
        #2 calib = 1'b0;
        repeat (4) @(posedge clk);
        #2 calib = 1'b1;
        wait_drain(200);

        // 3. Three timeouts reach FAIL; a retry pulse restarts the sequence.
        do_reset();
        exp_push(ST_WAIT, 0, 0, 4);
        exp_push(ST_RST, 1, 0, 20);
        exp_push(ST_WAIT, 1, 0, 4);
        exp_push(ST_RST, 2, 0, 20);
        exp_push(ST_WAIT, 2, 0, 4);
        exp_push(ST_FAIL, 3, 0, 20);
        wait_drain(300);
        repeat (5) @(negedge clk);
        chk("fail_hold_state", int'(state), ST_FAIL);
        chk("fail_hold_fail_o", int'(fail), 1);
        exp_push(ST_RST, 0, 0, -1);
        pulse_retry();
        wait_drain(50);

        // 4. Calibration lost in RUN.
        do_reset();
        exp_push(ST_WAIT, 0, 0, 4);
        exp_push(ST_SETTLE, 0, 0, 4);
        exp_push(ST_RUN, 0, 0, 8);
        repeat (5) @(posedge clk);
        #2 calib = 1'b1;
        wait_drain(200);
        repeat (5) @(posedge clk);
        exp_push(ST_RST, 0, 1, -1);
        exp_push(ST_WAIT, 0, 1, 4);
        exp_push(ST_SETTLE, 0, 1, -1);
        exp_push(ST_RUN, 0, 1, 8);
        #2 calib = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("loss_ddr_rst_3cyc", int'(ddr_rst), 1);
        chk("loss_soc_arst_3cyc", int'(soc_arst), 1);
        chk("loss_count", int'(losses), 1);
        @(posedge clk); #2 calib = 1'b1;
        wait_drain(200);

        // 5. Calibration seen on the timeout cycle goes to SETTLE; retry in RUN is ignored.
        do_reset();
        exp_push(ST_WAIT, 0, 0, 4);
        wait_drain(50);
        exp_push(ST_SETTLE, 0, 0, 20);
        exp_push(ST_RUN, 0, 0, 8);
        repeat (17) @(posedge clk);
        #2 calib = 1'b1;
        wait_drain(200);
        pulse_retry();
        repeat (5) @(negedge clk);
        chk("run_retry_state", int'(state), ST_RUN);
        chk("run_retry_ready", int'(ready), 1);

        // 6a. Reset asserted in SETTLE with retries_o nonzero.
        do_reset();
        exp_push(ST_WAIT, 0, 0, 4);
        exp_push(ST_RST, 1, 0, 20);
        exp_push(ST_WAIT, 1, 0, 4);
        wait_drain(200);
        exp_push(ST_SETTLE, 1, 0, -1);
        @(posedge clk); #2 calib = 1'b1;
        wait_drain(50);
        repeat (3) @(posedge clk);
        do_reset();

        // 6b. cke low for 10 cycles in WAIT_CALIB delays the timeout by 10 cycles.
        exp_push(ST_WAIT, 0, 0, 4);
        wait_drain(50);
        exp_push(ST_RST, 1, 0, 30);
        @(posedge clk); #2 cke = 1'b0;
        repeat (10) @(posedge clk);
        #2 cke = 1'b1;
        wait_drain(200);

        chk("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
